uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first; the receive end of the team's UART link.
- Consumes the TX line from the far end through RX; presents each received byte on DATA_OUT.
- Holds each byte with a ready flag until the consumer acknowledges it with TRG_READ.
- Sits beside the transmitter inside the UART wrapper and can also be instantiated standalone in benches.

Parameters:
- CLKS_PER_BIT, 434, CLK_50MHZ cycles per bit (50 MHz / 115200 baud); legal range 16..65535.
- SYNC_STAGES, 2, flip-flops in the RX metastability synchronizer; legal range 2..3.

Ports:
- CLK_50MHZ  in  1  main clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- RX  in  1  serial input; idles high.
- TRG_READ  in  1  consumer acknowledge; single-cycle pulse.
- DATA_OUT  out  8  last received byte.
- READY  out  1  byte available and not yet acknowledged.
- DONE  out  1  one-cycle pulse when a valid frame completes.
- BUSY  out  1  high from start-bit detection until the frame ends.
- FRAME_ERR  out  1  sticky; stop bit sampled low.
- OVERRUN  out  1  sticky; new byte completed while READY was still high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - DATA_OUT=8'h00; READY, DONE, BUSY, FRAME_ERR and OVERRUN all 0.
  - FSM returns to IDLE; synchronizer flops are set to 1.
- RX passes through SYNC_STAGES flip-flops; all decisions use the synchronized signal rxs.
- Bit counter runs 0..CLKS_PER_BIT-1; a mid-bit strobe fires at count CLKS_PER_BIT/2 (integer division).
- IDLE:
  - A falling edge on rxs moves to START, clears the counter and sets BUSY.
- START:
  - At the mid-bit strobe, rxs=0 moves to DATA.
  - At the mid-bit strobe, rxs=1 is a glitch: return to IDLE, BUSY=0, no flags change.
- DATA:
  - Sample at each mid-bit strobe and shift in LSB first.
  - After the 8th sample, move to STOP.
- STOP:
  - At the mid-bit strobe, rxs=1 gives a valid frame:
    - DATA_OUT loads the shift register.
    - DONE pulses for 1 cycle; READY is set.
    - If READY was already 1, OVERRUN is set and DATA_OUT is overwritten.
  - At the mid-bit strobe, rxs=0 sets FRAME_ERR. DATA_OUT, READY and DONE are unchanged.
  - In both cases, return to IDLE with BUSY=0.
  - After a framing error, the FSM waits in IDLE for rxs=1 before it re-arms.
- Latency: DONE asserts SYNC_STAGES+1 cycles after the midpoint of the stop bit on RX.
- TRG_READ:
  - Clears READY, FRAME_ERR and OVERRUN on the next edge.
  - If TRG_READ and a new DONE occur in the same cycle, DONE wins: READY stays 1 and OVERRUN is not set.
- A break condition (RX held low for a whole frame) produces FRAME_ERR and no DONE.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is ever presented.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it expects even parity over the 8 data bits.
  - Adds output PARITY_ERR (1 bit, sticky, cleared by TRG_READ, reset 0).
  - A parity mismatch sets PARITY_ERR and suppresses DONE and READY for that frame. DATA_OUT is unchanged.
- Undefined:
  - Frames are 8N1 and the PARITY_ERR port does not exist.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the DATA_BITS=8 constant;
  - a default CLKS_PER_BIT constant derived from 50_000_000/115200, shared with the transmitter.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES synchronizer with reset-to-1, reusable by other asynchronous inputs.

Test Plan:
- Release RST, drive 0x03, 0x06, 0x0C at 115200 baud with CLKS_PER_BIT=434 -> three DONE pulses; DATA_OUT reads 0x03, then 0x06, then 0x0C; FRAME_ERR=0.
- Drive a 100-cycle low glitch on idle RX -> no DONE; BUSY returns to 0 within 218 cycles; state is IDLE.
- Send 0xA5 with stop bit forced low -> FRAME_ERR=1, READY=0, DATA_OUT keeps its previous value; the next valid 0x5A is still received.
- Send 0x11 then 0x22 without TRG_READ -> OVERRUN=1, DATA_OUT=0x22; a TRG_READ pulse clears READY and OVERRUN.
- Assert RST during bit 4 of 0xFF -> all outputs are at reset values; the following 0x3C is received correctly.
- With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> PARITY_ERR=1, no DONE; with parity bit 1 -> DONE, DATA_OUT=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default bit period for a 50 MHz clock at 115200 baud.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 50_000_000 / 115200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous level input; flops reset to 1
// so an idle-high line never shows a false falling edge out of reset.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on the synchronized line.
// Define UART_RX_PARITY_EN to add an even-parity bit and the PARITY_ERR output.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX,
  input  logic       TRG_READ,
  output logic [7:0] DATA_OUT,
  output logic       READY,
  output logic       DONE,
  output logic       BUSY,
  output logic       FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic       PARITY_ERR,
`endif
  output logic       OVERRUN
);

  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  logic                 rxs, rxs_prev_q;
  rx_state_e            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_q, sr_d, data_q, data_d;
  logic                 ready_q, ready_d, done_q, done_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 strobe;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d, par_bad_q, par_bad_d;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK_50MHZ),
    .rst (RST),
    .d   (RX),
    .q   (rxs)
  );

  assign strobe = (cnt_q == CNT_HALF);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    // Acknowledge clears first; a completing frame below overrides it.
    ready_d = ready_q & ~TRG_READ;
    ferr_d  = ferr_q & ~TRG_READ;
    ovr_d   = ovr_q & ~TRG_READ;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q & ~TRG_READ;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        // Edge detect also keeps us parked after a break until the line recovers.
        if (rxs_prev_q && !rxs) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (strobe) begin
          state_d = rxs ? IDLE : DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (strobe) begin
          sr_d  = {rxs, sr_q[DATA_BITS-1:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (strobe) begin
          par_bad_d = ^{sr_q, rxs};
          perr_d    = perr_d | par_bad_d;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (!rxs) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!par_bad_q) begin
`else
          end else begin
`endif
            data_d  = sr_q;
            done_d  = 1'b1;
            ready_d = 1'b1;
            if (ready_q && !TRG_READ) ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rxs_prev_q <= 1'b1;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      sr_q       <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rxs_prev_q <= rxs;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  assign DATA_OUT  = data_q;
  assign READY     = ready_q;
  assign DONE      = done_q;
  assign BUSY      = (state_q != IDLE);
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 115200 baud on a 50 MHz clock.
module tb_uart_rx_core;

  localparam int CPB  = 434;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, rx, trg;
  logic [7:0] data_out;
  logic       ready, done, busy, ferr, ovr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int checks = 0, errors = 0;
  int done_cnt = 0, done_cyc = 0, cyc = 0, t_start = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .RX        (rx),
    .TRG_READ  (trg),
    .DATA_OUT  (data_out),
    .READY     (ready),
    .DONE      (done),
    .BUSY      (busy),
    .FRAME_ERR (ferr),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR(perr),
`endif
    .OVERRUN   (ovr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b,
                           input logic par_en, input logic par_b);
    @(negedge clk);
    t_start = cyc;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    if (par_en) begin
      rx = par_b;
      idle(CPB);
    end
    rx = stop_b;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    @(negedge clk) trg = 1'b1;
    @(negedge clk) trg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; trg = 1'b0;
    idle(5);
    checks++;
    if ({data_out, ready, done, busy, ferr, ovr} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {data_out, ready, done, busy, ferr, ovr});
    end
    @(negedge clk) rst = 1'b0;
    idle(20);
  endtask

  task automatic test_basic();
    logic [7:0] tbl [3] = '{8'h03, 8'h06, 8'h0C};
    int d0;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      send_byte(tbl[i], 1'b1, 1'b0, 1'b0);
      idle(20);
      checks++;
      if (done_cnt !== d0 + 1 || data_out !== tbl[i] || ferr !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_%0d got done=%0d data=%h ferr=%b ready=%b want done=%0d data=%h ferr=0 ready=1",
                 i, done_cnt - d0, data_out, ferr, ready, 1, tbl[i]);
      end
      if (i == 0) begin
        checks++;
        if (done_cyc - t_start < 9*CPB + CPB/2 + SYNC || done_cyc - t_start > 9*CPB + CPB/2 + SYNC + 4) begin
          errors++;
          $display("FAIL done_latency got %0d want %0d..%0d", done_cyc - t_start,
                   9*CPB + CPB/2 + SYNC, 9*CPB + CPB/2 + SYNC + 4);
        end
      end
      pulse_read();
      idle(1);
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_read_clear got ready=%b want 0", ready);
      end
    end
  endtask

  task automatic test_glitch();
    int d0, n;
    d0 = done_cnt;
    @(negedge clk) rx = 1'b0;
    idle(100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_set got %b want 1", busy);
    end
    rx = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 218) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_timeout got busy=%b after %0d cycles want 0", busy, n);
    end
    idle(500);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_frame got done=%0d busy=%b ready=%b want 0 0 0", done_cnt - d0, busy, ready);
    end
  endtask

  task automatic test_frame_err();
    int d0;
    d0 = done_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (ferr !== 1'b1 || ready !== 1'b0 || data_out !== 8'h0C || done_cnt !== d0) begin
      errors++;
      $display("FAIL frame_err got ferr=%b ready=%b data=%h done=%0d want 1 0 0c 0",
               ferr, ready, data_out, done_cnt - d0);
    end
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (done_cnt !== d0 + 1 || data_out !== 8'h5A || ferr !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_recover got done=%0d data=%h ferr=%b want 1 5a 1",
               done_cnt - d0, data_out, ferr);
    end
    pulse_read();
    idle(1);
    checks++;
    if (ferr !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clear got ferr=%b ready=%b want 0 0", ferr, ready);
    end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (ovr !== 1'b0 || data_out !== 8'h11) begin
      errors++;
      $display("FAIL overrun_first got ovr=%b data=%h want 0 11", ovr, data_out);
    end
    send_byte(8'h22, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (ovr !== 1'b1 || data_out !== 8'h22 || ready !== 1'b1 || done_cnt !== d0 + 2) begin
      errors++;
      $display("FAIL overrun_set got ovr=%b data=%h ready=%b done=%0d want 1 22 1 2",
               ovr, data_out, ready, done_cnt - d0);
    end
    pulse_read();
    idle(1);
    checks++;
    if (ovr !== 1'b0 || ready !== 1'b0 || data_out !== 8'h22) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b ready=%b data=%h want 0 0 22", ovr, ready, data_out);
    end
  endtask

  task automatic test_reset_midframe();
    int d0;
    @(negedge clk) rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(4*CPB + CPB/2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy got %b want 1", busy);
    end
    rst = 1'b1;
    idle(3);
    checks++;
    if ({data_out, ready, done, busy, ferr, ovr} !== 13'h0) begin
      errors++;
      $display("FAIL midframe_reset got %h want 0", {data_out, ready, done, busy, ferr, ovr});
    end
    rst = 1'b0;
    idle(20);
    d0 = done_cnt;
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (done_cnt !== d0 + 1 || data_out !== 8'h3C || ferr !== 1'b0) begin
      errors++;
      $display("FAIL midframe_recover got done=%0d data=%h ferr=%b want 1 3c 0",
               done_cnt - d0, data_out, ferr);
    end
    pulse_read();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int d0;
    idle(20);
    d0 = done_cnt;
    send_byte(8'h07, 1'b1, 1'b1, 1'b0);
    idle(20);
    checks++;
    if (perr !== 1'b1 || done_cnt !== d0 || ready !== 1'b0 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL parity_bad got perr=%b done=%0d ready=%b data=%h want 1 0 0 3c",
               perr, done_cnt - d0, ready, data_out);
    end
    pulse_read();
    idle(20);
    send_byte(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (perr !== 1'b0 || done_cnt !== d0 + 1 || data_out !== 8'h07) begin
      errors++;
      $display("FAIL parity_good got perr=%b done=%0d data=%h want 0 1 07",
               perr, done_cnt - d0, data_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
